// File: rtl/sort_result_rx.sv
// Receives one sorted frame of M words, buffers it, then checks that it is non-decreasing.
// Define SORT_RX_FLOAT_CMP_EN to order words as sign-magnitude floats instead of signed integers.
module sort_result_rx #(
   parameter int M = 8,
   parameter int N = 32
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic [N-1:0]           in_data,
   input  logic                   in_valid,
   input  logic [$clog2(M)-1:0]   rd_addr,
   output logic [N-1:0]           rd_data,
   output logic                   busy,
   output logic                   done,
   output logic                   sorted_ok,
   output logic [$clog2(M):0]     err_count,
   output logic                   short_frame
);

   localparam int AW = $clog2(M);

   typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DONE} state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  wr_idx_q, wr_idx_d;
   logic [AW-1:0]  chk_idx_q, chk_idx_d;
   logic [AW:0]    err_q, err_d;
   logic           done_q, done_d;
   logic           ok_q, ok_d;
   logic           short_q, short_d;
   logic           busy_q, busy_d;
   logic [N-1:0]   rd_q, rd_d;
   logic [N-1:0]   mem_q [M];

   logic           wr_en;
   logic [AW-1:0]  wr_addr;
   logic [AW-1:0]  prev_idx;
   logic           viol;

   function automatic logic greater(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef SORT_RX_FLOAT_CMP_EN
      if (a[N-1] != b[N-1])
         greater = ~a[N-1];
      else if (!a[N-1])
         greater = (a[N-2:0] > b[N-2:0]);
      else
         greater = (a[N-2:0] < b[N-2:0]);
`else
      greater = ($signed(a) > $signed(b));
`endif
   endfunction

   always_comb begin
      state_d   = state_q;
      wr_idx_d  = wr_idx_q;
      chk_idx_d = chk_idx_q;
      err_d     = err_q;
      done_d    = done_q;
      ok_d      = ok_q;
      short_d   = short_q;
      wr_en     = 1'b0;
      wr_addr   = wr_idx_q;
      prev_idx  = chk_idx_q - AW'(1);
      viol      = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               wr_en    = 1'b1;
               wr_addr  = '0;
               wr_idx_d = AW'(1);
               state_d  = COLLECT;
            end
         end
         COLLECT: begin
            if (in_valid) begin
               wr_en = 1'b1;
               if (wr_idx_q == AW'(M - 1)) begin
                  state_d   = CHECK;
                  chk_idx_d = AW'(1);
                  err_d     = '0;
               end else begin
                  wr_idx_d = wr_idx_q + AW'(1);
               end
            end else begin
               // Sorter stopped early: report a truncated frame without checking it.
               short_d = 1'b1;
               ok_d    = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         CHECK: begin
            viol  = greater(mem_q[prev_idx], mem_q[chk_idx_q]);
            err_d = err_q + (AW+1)'(viol);
            if (chk_idx_q == AW'(M - 1)) begin
               done_d  = 1'b1;
               ok_d    = (err_d == '0);
               state_d = DONE;
            end else begin
               chk_idx_d = chk_idx_q + AW'(1);
            end
         end
         DONE: begin
            if (in_valid) begin
               done_d   = 1'b0;
               ok_d     = 1'b0;
               short_d  = 1'b0;
               err_d    = '0;
               wr_en    = 1'b1;
               wr_addr  = '0;
               wr_idx_d = AW'(1);
               state_d  = COLLECT;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == COLLECT) || (state_d == CHECK);

      if ({1'b0, rd_addr} < (AW+1)'(M))
         rd_d = mem_q[rd_addr];
      else
         rd_d = '0;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_idx_q  <= '0;
         chk_idx_q <= '0;
         err_q     <= '0;
         done_q    <= 1'b0;
         ok_q      <= 1'b0;
         short_q   <= 1'b0;
         busy_q    <= 1'b0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         wr_idx_q  <= wr_idx_d;
         chk_idx_q <= chk_idx_d;
         err_q     <= err_d;
         done_q    <= done_d;
         ok_q      <= ok_d;
         short_q   <= short_d;
         busy_q    <= busy_d;
         rd_q      <= rd_d;
      end
   end

   // Buffer is deliberately left out of reset; rst still blocks a same-cycle write.
   always_ff @(posedge clock) begin
      if (wr_en && !rst)
         mem_q[wr_addr] <= in_data;
   end

   assign rd_data     = rd_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign sorted_ok   = ok_q;
   assign err_count   = err_q;
   assign short_frame = short_q;

endmodule

// File: tb/tb_sort_result_rx.sv
// Self-checking bench for sort_result_rx: table-driven frames with a result scoreboard,
// plus hand-written reset, CHECK-phase and readback sequences.
module tb_sort_result_rx;

   localparam int M  = 8;
   localparam int N  = 32;
   localparam int AW = $clog2(M);

   logic           clock = 1'b0;
   logic           rst;
   logic [N-1:0]   in_data;
   logic           in_valid;
   logic [AW-1:0]  rd_addr;
   logic [N-1:0]   rd_data;
   logic           busy, done, sorted_ok, short_frame;
   logic [AW:0]    err_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N-1:0] w [M];
      int           n;
      bit           exp_ok;
      int           exp_err;
      bit           exp_short;
   } vec_t;

   typedef struct {
      bit ok;
      int err;
      bit shrt;
      int lat;
   } exp_t;

   vec_t         tbl [$];
   exp_t         sb [$];
   logic [N-1:0] shadow [M];

   sort_result_rx #(.M(M), .N(N)) dut (
      .clock      (clock),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .sorted_ok  (sorted_ok),
      .err_count  (err_count),
      .short_frame(short_frame)
   );

   always #5 clock = ~clock;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Bench-side ordering: map each word to an unsigned key whose order matches the float order.
   function automatic bit tb_gt(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef SORT_RX_FLOAT_CMP_EN
      logic [N-1:0] ka, kb;
      ka = a[N-1] ? {1'b0, ~a[N-2:0]} : {1'b1, a[N-2:0]};
      kb = b[N-1] ? {1'b0, ~b[N-2:0]} : {1'b1, b[N-2:0]};
      return ka > kb;
`else
      return $signed(a) > $signed(b);
`endif
   endfunction

   task automatic apply_stimulus(input vec_t v, input int poke);
      exp_t         e;
      int           cycles;
      logic [N-1:0] old_rd;
      for (int i = 0; i < v.n; i++) begin
         @(negedge clock);
         in_valid = 1'b1;
         in_data  = v.w[i];
         old_rd   = shadow[rd_addr];
         @(posedge clock);
         #1;
         shadow[i] = v.w[i];
         if (!$isunknown(old_rd))
            check_output("rd_old_data", rd_data, old_rd);
         if (i == 0) begin
            check_output("first_done_clr", done, 0);
            check_output("first_busy", busy, 1);
            check_output("first_short_clr", short_frame, 0);
            check_output("first_ok_clr", sorted_ok, 0);
            check_output("first_err_clr", err_count, 0);
         end
      end
      e.ok   = v.exp_ok;
      e.err  = v.exp_err;
      e.shrt = v.exp_short;
      e.lat  = v.exp_short ? 1 : M - 1;
      sb.push_back(e);

      cycles = 0;
      for (int k = 0; k < poke; k++) begin
         @(negedge clock);
         in_valid = 1'b1;
         in_data  = 32'h0000_0099;
         @(posedge clock);
         #1;
         cycles++;
      end
      @(negedge clock);
      in_valid = 1'b0;
      while (!done && cycles < 20) begin
         @(posedge clock);
         #1;
         cycles++;
      end

      e = sb.pop_front();
      check_output("done_seen", done, 1);
      check_output("latency", cycles, e.lat);
      check_output("sorted_ok", sorted_ok, e.ok);
      check_output("err_count", err_count, e.err);
      check_output("short_frame", short_frame, e.shrt);
      check_output("busy_done", busy, 0);
      repeat (3) @(posedge clock);
      #1;
      check_output("hold_done", done, 1);
      check_output("hold_ok", sorted_ok, e.ok);
      check_output("hold_err", err_count, e.err);
      check_output("hold_short", short_frame, e.shrt);
   endtask

   task automatic read_back(input int addr, input logic [N-1:0] exp);
      @(negedge clock);
      rd_addr = AW'(addr);
      @(posedge clock);
      #1;
      check_output($sformatf("rd_data[%0d]", addr), rd_data, exp);
   endtask

   task automatic add_vec(input logic [N-1:0] w [M], input int n, input bit ok, input int err, input bit shrt);
      vec_t v;
      v.w = w;
      v.n = n;
      v.exp_ok = ok;
      v.exp_err = err;
      v.exp_short = shrt;
      tbl.push_back(v);
   endtask

   initial begin
      vec_t         v;
      logic [N-1:0] w [M];
      int           done_hits;
      int           cnt;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      rd_addr  = '0;

      w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      add_vec(w, 8, 1'b1, 0, 1'b0);
      w = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      add_vec(w, 8, 1'b0, 7, 1'b0);
`ifdef SORT_RX_FLOAT_CMP_EN
      w = '{32'hBF80_0000, 32'h8000_0000, 32'h0000_0000, 32'h3F80_0000,
            32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
      add_vec(w, 8, 1'b1, 0, 1'b0);
      w = '{32'h8000_0000, 32'hBF80_0000, 32'h0000_0000, 32'h3F80_0000,
            32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
      add_vec(w, 8, 1'b0, 1, 1'b0);
`else
      w = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd2, 32'd2, 32'd5, 32'd9};
      add_vec(w, 8, 1'b1, 0, 1'b0);
      w = '{32'd5, 32'hFFFF_FFFB, 32'd0, 32'd7, 32'd7, 32'd6, 32'd10, 32'd11};
      add_vec(w, 8, 1'b0, 2, 1'b0);
`endif
      w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd0, 32'd0};
      add_vec(w, 5, 1'b0, 0, 1'b1);
      w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      add_vec(w, 8, 1'b1, 0, 1'b0);

      repeat (3) @(posedge clock);
      #1;
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_ok", sorted_ok, 0);
      check_output("rst_err", err_count, 0);
      check_output("rst_short", short_frame, 0);
      check_output("rst_rd_data", rd_data, 0);
      @(negedge clock);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply_stimulus(tbl[i], 0);
         if (i == 0) begin
            read_back(3, 32'd4);
            for (int a = 0; a < M; a++)
               read_back(a, shadow[a]);
         end
      end

      // Words arriving during CHECK must be ignored entirely.
      $display("[TB] in_valid during CHECK");
      @(negedge clock);
      rd_addr = '0;
      w = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
      v.w = w; v.n = 8; v.exp_ok = 1'b1; v.exp_err = 0; v.exp_short = 1'b0;
      apply_stimulus(v, 2);
      for (int a = 0; a < M; a++)
         read_back(a, 32'(10 * (a + 1)));

      // Reset coincident with the 4th word abandons the frame.
      $display("[TB] reset mid-frame");
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         in_valid = 1'b1;
         in_data  = 32'(100 + i);
         rst      = (i == 3);
         @(posedge clock);
         #1;
         if (i < 3)
            shadow[i] = 32'(100 + i);
      end
      check_output("midrst_busy", busy, 0);
      check_output("midrst_done", done, 0);
      check_output("midrst_ok", sorted_ok, 0);
      check_output("midrst_err", err_count, 0);
      check_output("midrst_short", short_frame, 0);
      check_output("midrst_rd_data", rd_data, 0);
      @(negedge clock);
      rst = 1'b0;
      in_valid = 1'b0;
      done_hits = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clock);
         #1;
         if (done) done_hits++;
      end
      check_output("midrst_no_done", done_hits, 0);
      read_back(3, 32'd40);
      read_back(2, 32'd102);
      w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      v.w = w; v.n = 8; v.exp_ok = 1'b1; v.exp_err = 0; v.exp_short = 1'b0;
      apply_stimulus(v, 0);

      // Random frames, expectations from the bench ordering model.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < M; i++)
            w[i] = 32'(int'($urandom_range(0, 40)) - 20);
         cnt = 0;
         for (int i = 1; i < M; i++)
            if (tb_gt(w[i-1], w[i])) cnt++;
         v.w = w; v.n = 8; v.exp_ok = (cnt == 0); v.exp_err = cnt; v.exp_short = 1'b0;
         apply_stimulus(v, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sort_result_rx.md
SORT_RESULT_RX -- requirements
Module: sort_result_rx

Interface
REQ-001 M, 8, number of words per frame; legal values are M >= 2.
REQ-002 N, 32, data word width in bits.
REQ-003 clock  input  1  single rising-edge clock for all logic.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_data  input  N  sorted word from the sorter's outP.
REQ-006 in_valid  input  1  in_data is valid this cycle; driven from the sorter's outvalid.
REQ-007 rd_addr  input  clog2(M)  readback buffer index.
REQ-008 rd_data  output  N  buffer word at rd_addr, registered.
REQ-009 busy  output  1  high while a frame is being collected or checked.
REQ-010 done  output  1  a frame result is valid.
REQ-011 sorted_ok  output  1  the frame was complete and non-decreasing.
REQ-012 err_count  output  clog2(M)+1  number of adjacent-pair order violations.
REQ-013 short_frame  output  1  in_valid dropped before M words were received.

Function
REQ-014 The block SHALL hold an M x N word buffer and a four-state FSM: IDLE, COLLECT, CHECK, DONE.
REQ-015 IDLE, in_valid=1: SHALL write in_data to buf[0], set wr_idx=1, and go to COLLECT.
REQ-016 COLLECT, in_valid=1: SHALL write buf[wr_idx] and increment wr_idx; the write at wr_idx=M-1 SHALL go to CHECK with chk_idx=1 and err_count=0.
REQ-017 COLLECT, in_valid=0: SHALL set short_frame=1, sorted_ok=0, done=1 and go to DONE, skipping CHECK.
REQ-018 CHECK SHALL compare one pair per cycle: if buf[chk_idx-1] > buf[chk_idx], err_count SHALL increment; chk_idx SHALL then increment.
REQ-019 The CHECK compare at chk_idx=M-1 SHALL go to DONE with done=1 and sorted_ok=(final err_count==0).
REQ-020 Latency: if the last word is written at edge T, done SHALL be visible after edge T+M-1, i.e. M-1 compare cycles.
REQ-021 in_valid during CHECK SHALL be ignored: no buffer write, no state or flag change.
REQ-022 DONE SHALL hold done, sorted_ok, err_count and short_frame stable until the next in_valid=1.
REQ-023 DONE, in_valid=1: SHALL clear all four flags in the same edge, write buf[0], set wr_idx=1, and go to COLLECT.
REQ-024 busy SHALL be 1 exactly in COLLECT and CHECK.
REQ-025 rd_data SHALL load buf[rd_addr] every cycle, in any state, with 1-cycle latency.
REQ-026 A same-cycle write to the address being read SHALL return the old data.
REQ-027 rd_addr >= M SHALL return rd_data=0.
REQ-028 Default comparison SHALL be signed two's-complement over N bits; equal words are not a violation.

Reset
REQ-029 rst=1 SHALL force the state to IDLE and set wr_idx, chk_idx, busy, done, sorted_ok, err_count, short_frame and rd_data to 0.
REQ-030 Buffer contents SHALL NOT be cleared by reset.
REQ-031 rst during COLLECT or CHECK SHALL abandon the frame without asserting done; rst SHALL have priority over in_valid in the same cycle.

Configuration
REQ-032 With SORT_RX_FLOAT_CMP_EN defined, comparison SHALL use sign-magnitude float ordering:
- bit N-1=1 is less than bit N-1=0;
- both non-negative: larger bits [N-2:0] is greater;
- both negative: larger bits [N-2:0] is lesser;
- -0 < +0.
REQ-033 Without SORT_RX_FLOAT_CMP_EN, comparison SHALL be the signed compare of REQ-028, and no float-compare logic SHALL be present.

Verification
REQ-034 M=8, words 1..8 on consecutive cycles -> done=1 seven cycles after the last word, sorted_ok=1, err_count=0; then rd_addr=3 -> rd_data=4 one cycle later.
REQ-035 Words 8,7,6,5,4,3,2,1 -> err_count=7, sorted_ok=0, short_frame=0.
REQ-036 Macro off, words -3,-1,0,0,2,2,5,9 -> sorted_ok=1, err_count=0.
REQ-037 in_valid drops after 5 words -> done=1 and short_frame=1 on the next edge, sorted_ok=0, no CHECK cycles; a following full frame 1..8 -> flags cleared, then sorted_ok=1.
REQ-038 rst pulsed at the 4th word of a frame -> all outputs 0 and done never asserted; the next frame 1..8 -> sorted_ok=1.
REQ-039 Macro on, frame 0xBF800000, 0x80000000, 0x00000000, 0x3F800000, 0x40000000 x4 -> sorted_ok=1; swap the first two words -> err_count=1.
